// File: rtl/program_rom_if.sv
// Fetch bus between the Jac1-8 fetch stage and the program ROM:
// the fetch stage drives the program counter, the ROM returns the instruction word.
interface program_rom_if #(
  parameter int PC_WIDTH  = 8,
  parameter int DataWidth = 16
);
  logic [PC_WIDTH-1:0]  pc;
  logic [DataWidth-1:0] ir;

  modport master (output pc, input ir);
  modport slave  (input pc, output ir);
endinterface

// File: rtl/program_rom.sv
// program_rom: read-only boot program store of the Jac1-8 CPU.
// Default: registered synchronous read, one-cycle latency, async active-low clear.
// Build option PROGMEM_COMB_READ_EN: ir follows pc combinationally (clk unused).
// Addresses at or above CMD_CNT read as zero.
module program_rom #(
  parameter int PC_WIDTH  = 8,
  parameter int DataWidth = 16,
  parameter int CMD_CNT   = 64
) (
  input  logic          clk,
  input  logic          res_n,
  program_rom_if.slave  bus
);

  // Fixed boot image; unlisted addresses and anything past CMD_CNT read as zero.
  function automatic logic [DataWidth-1:0] rom_word(input logic [PC_WIDTH-1:0] addr);
    int unsigned idx;
    logic [15:0] w;
    idx = 32'(addr);
    w   = '0;
    if (idx < 32'(CMD_CNT)) begin
      case (idx)
        0:  w = 16'h4903;
        1:  w = 16'h4A14;
        2:  w = 16'h4BF0;
        3:  w = 16'h0910;
        4:  w = 16'h1918;
        5:  w = 16'h480F;
        6:  w = 16'h2008;
        7:  w = 16'h2918;
        8:  w = 16'h3308;
        9:  w = 16'h1308;
        10: w = 16'h8802;
        13: w = 16'h3902;
        14: w = 16'h4204;
        15: w = 16'h9003;
        19: w = 16'h1210;
        20: w = 16'h8801;
        22: w = 16'h9801;
        24: w = 16'h0910;
        25: w = 16'h9801;
        27: w = 16'h5100;
        28: w = 16'h5008;
        29: w = 16'h8008;
        default: w = '0;
      endcase
    end
    return DataWidth'(w);
  endfunction

`ifdef PROGMEM_COMB_READ_EN
  // Combinational read: zero-latency lookup, forced to zero while in reset.
  always_comb begin
    bus.ir = '0;
    if (res_n) bus.ir = rom_word(bus.pc);
  end
`else
  logic [DataWidth-1:0] ir_q;

  // Registered read: sample pc on each rising edge, clear asynchronously in reset.
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) ir_q <= '0;
    else        ir_q <= rom_word(bus.pc);
  end

  assign bus.ir = ir_q;
`endif

endmodule

// File: tb/tb_program_rom.sv
// Self-checking bench for program_rom: directed scenarios plus randomized fetches
// compared against an array model of the boot image.
module tb_program_rom;

  localparam int PC_WIDTH  = 8;
  localparam int DataWidth = 16;
  localparam int CMD_CNT   = 64;

  logic clk;
  logic res_n;

  program_rom_if #(.PC_WIDTH(PC_WIDTH), .DataWidth(DataWidth)) bif ();

  program_rom #(
    .PC_WIDTH (PC_WIDTH),
    .DataWidth(DataWidth),
    .CMD_CNT  (CMD_CNT)
  ) dut (
    .clk  (clk),
    .res_n(res_n),
    .bus  (bif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors;
  int miscompares;

  // Reference image: whole address space, zero outside the programmed words.
  logic [15:0] ref_mem [0:255];

  function automatic logic [15:0] ref_word(input int unsigned a);
    if (a >= CMD_CNT) return 16'h0000;
    return ref_mem[a];
  endfunction

  task automatic init_model();
    for (int i = 0; i < 256; i++) ref_mem[i] = 16'h0000;
    ref_mem[0]  = 16'h4903; ref_mem[1]  = 16'h4A14; ref_mem[2]  = 16'h4BF0;
    ref_mem[3]  = 16'h0910; ref_mem[4]  = 16'h1918; ref_mem[5]  = 16'h480F;
    ref_mem[6]  = 16'h2008; ref_mem[7]  = 16'h2918; ref_mem[8]  = 16'h3308;
    ref_mem[9]  = 16'h1308; ref_mem[10] = 16'h8802; ref_mem[13] = 16'h3902;
    ref_mem[14] = 16'h4204; ref_mem[15] = 16'h9003; ref_mem[19] = 16'h1210;
    ref_mem[20] = 16'h8801; ref_mem[22] = 16'h9801; ref_mem[24] = 16'h0910;
    ref_mem[25] = 16'h9801; ref_mem[27] = 16'h5100; ref_mem[28] = 16'h5008;
    ref_mem[29] = 16'h8008;
  endtask

  // Present an address between edges and move to just after the next rising edge.
  task automatic step(input int unsigned a);
    @(negedge clk);
    bif.pc = PC_WIDTH'(a);
`ifdef PROGMEM_COMB_READ_EN
    #1;
`else
    @(posedge clk);
    #1;
`endif
  endtask

  task automatic test_reset();
    res_n  = 1'b0;
    bif.pc = '0;
    #10;
    vectors++;
    if (bif.ir !== 16'h0000) begin
      miscompares++;
      $display("FAIL reset_clear got=%h want=0000", bif.ir);
    end
    // Clock edges while held in reset must not load anything.
    bif.pc = 8'd3;
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if (bif.ir !== 16'h0000) begin
      miscompares++;
      $display("FAIL reset_hold got=%h want=0000", bif.ir);
    end
  endtask

  task automatic test_first_fetch();
    @(negedge clk);
    res_n = 1'b1;
    step(0);
    vectors++;
    if (bif.ir !== 16'h4903) begin
      miscompares++;
      $display("FAIL first_fetch got=%h want=4903", bif.ir);
    end
  endtask

  task automatic test_sequential();
    for (int unsigned p = 1; p <= 29; p++) begin
      step(p);
      vectors++;
      if (bif.ir !== ref_word(p)) begin
        miscompares++;
        $display("FAIL seq_fetch pc=%0d got=%h want=%h", p, bif.ir, ref_word(p));
      end
    end
  endtask

  task automatic test_spot_values();
    int unsigned pcs  [8] = '{2, 10, 15, 29, 11, 16, 21, 26};
    logic [15:0] want [8] = '{16'h4BF0, 16'h8802, 16'h9003, 16'h8008,
                              16'h0000, 16'h0000, 16'h0000, 16'h0000};
    for (int i = 0; i < 8; i++) begin
      // Precede with a nonzero word so a stuck output cannot pass the zero slots.
      step(0);
      step(pcs[i]);
      vectors++;
      if (bif.ir !== want[i]) begin
        miscompares++;
        $display("FAIL spot_value pc=%0d got=%h want=%h", pcs[i], bif.ir, want[i]);
      end
    end
  endtask

  task automatic test_out_of_range();
    int unsigned pcs [4] = '{30, 63, 64, 255};
    for (int i = 0; i < 4; i++) begin
      step(1);
      step(pcs[i]);
      vectors++;
      if (bif.ir !== 16'h0000) begin
        miscompares++;
        $display("FAIL out_of_range pc=%0d got=%h want=0000", pcs[i], bif.ir);
      end
    end
  endtask

  task automatic test_mid_reset();
    step(5);
    vectors++;
    if (bif.ir !== 16'h480F) begin
      miscompares++;
      $display("FAIL mid_reset_load got=%h want=480F", bif.ir);
    end
    #2 res_n = 1'b0;
    #1;
    vectors++;
    if (bif.ir !== 16'h0000) begin
      miscompares++;
      $display("FAIL mid_reset_async got=%h want=0000", bif.ir);
    end
    bif.pc = 8'd7;
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if (bif.ir !== 16'h0000) begin
      miscompares++;
      $display("FAIL mid_reset_hold got=%h want=0000", bif.ir);
    end
    @(negedge clk);
    res_n = 1'b1;
    step(5);
    vectors++;
    if (bif.ir !== 16'h480F) begin
      miscompares++;
      $display("FAIL mid_reset_release got=%h want=480F", bif.ir);
    end
  endtask

  task automatic test_back_to_back_random();
    int unsigned a;
    for (int i = 0; i < 300; i++) begin
      a = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 255) : $urandom_range(0, 31);
      step(a);
      vectors++;
      if (bif.ir !== ref_word(a)) begin
        miscompares++;
        $display("FAIL random_fetch pc=%0d got=%h want=%h", a, bif.ir, ref_word(a));
      end
    end
  endtask

`ifdef PROGMEM_COMB_READ_EN
  task automatic test_comb_read();
    @(negedge clk);
    bif.pc = 8'd13;
    #1;
    vectors++;
    if (bif.ir !== 16'h3902) begin
      miscompares++;
      $display("FAIL comb_read got=%h want=3902", bif.ir);
    end
  endtask
`endif

  initial begin
    vectors     = 0;
    miscompares = 0;
    init_model();
    test_reset();
    test_first_fetch();
    test_sequential();
    test_spot_values();
    test_out_of_range();
    test_mid_reset();
    test_back_to_back_random();
`ifdef PROGMEM_COMB_READ_EN
    test_comb_read();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
